// File: rtl/test_sequencer_pkg.sv
// Shared definitions for the test sequencer: register map, control/status
// bit positions, FSM state encoding and the randomiser feedback mask.
package test_seq_pkg;

   // Avalon byte offsets of the host-visible registers
   localparam logic [3:0] CTRL_ADDR  = 4'h0;
   localparam logic [3:0] COUNT_ADDR = 4'h4;
   localparam logic [3:0] DONE_ADDR  = 4'h8;
   localparam logic [3:0] CHK_ADDR   = 4'hC;

   // CTRL write bits (self-clearing pulses)
   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_ABORT_BIT = 1;

   // CTRL read (status) bits
   localparam int STAT_BUSY_BIT    = 0;
   localparam int STAT_DONE_BIT    = 1;
   localparam int STAT_TIMEOUT_BIT = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN_A,
      S_GEN_B,
      S_ISSUE,
      S_WAIT_RES,
      S_DONE
   } seq_state_e;

   // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (maximal length at 32 bits)
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/test_sequencer_if.sv
// Bus bundle of the test sequencer: the Avalon-MM slave port from the host
// and the operand/result handshake towards the unit under test.
// 'slave' is the sequencer's view, 'master' is the host + DUT environment view.
interface test_sequencer_if #(
   parameter int WIDTH = 32
) ();

   logic [3:0]       slave_address;
   logic             slave_read;
   logic             slave_write;
   logic [WIDTH-1:0] slave_writedata;
   logic [WIDTH-1:0] slave_readdata;

   logic [WIDTH-1:0] dut_a;
   logic [WIDTH-1:0] dut_b;
   logic             dut_valid;
   logic             dut_ready;
   logic [WIDTH-1:0] dut_o;
   logic             dut_o_valid;

   modport slave (
      input  slave_address, slave_read, slave_write, slave_writedata,
      output slave_readdata,
      output dut_a, dut_b, dut_valid,
      input  dut_ready, dut_o, dut_o_valid
   );

   modport master (
      output slave_address, slave_read, slave_write, slave_writedata,
      input  slave_readdata,
      input  dut_a, dut_b, dut_valid,
      output dut_ready, dut_o, dut_o_valid
   );

endinterface

// File: rtl/test_sequencer_rng.sv
// Operand randomiser: a Galois LFSR that holds its value and advances one
// step per cycle while enable is high. o is the current register value.
module test_sequencer_rng
   import test_seq_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] i_initial = 'hFFFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] o
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);

   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;

   // Next LFSR value: one Galois shift when enabled, otherwise hold
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      lfsr_d = lfsr_q;
      if (enable) begin
         lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
      end
   end

   // LFSR register, seeded by reset (a non-zero seed keeps it out of the all-zero lock-up state)
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         lfsr_q <= i_initial;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign o = lfsr_q;

endmodule

// File: rtl/test_sequencer.sv
// Test sequencer: host programs COUNT and pulses START over Avalon-MM; the
// sequencer draws operand pairs from the randomiser, hands them to the unit
// under test over valid/ready, and folds every result into a rotate-xor
// checksum. Optional watchdog in WAIT_RES: define TEST_SEQ_TIMEOUT_EN.
module test_sequencer
   import test_seq_pkg::*;
#(
   parameter int               WIDTH          = 32,
   parameter logic [WIDTH-1:0] SEED           = 'hFFFF,
   parameter int               TIMEOUT_CYCLES = 1024
) (
   input logic             clk,
   input logic             reset,
   test_sequencer_if.slave bus
);

   seq_state_e       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic [WIDTH-1:0] done_cnt_q, done_cnt_d;
   logic [WIDTH-1:0] checksum_q, checksum_d;
   logic [WIDTH-1:0] dut_a_q, dut_a_d;
   logic [WIDTH-1:0] dut_b_q, dut_b_d;
   logic [WIDTH-1:0] readdata_q, readdata_d;
   logic             done_q, done_d;
   logic             timeout_flag;

`ifdef TEST_SEQ_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              timeout_q, timeout_d;
   assign timeout_flag = timeout_q;
`else
   assign timeout_flag = 1'b0;
`endif

   logic             rng_enable;
   logic [WIDTH-1:0] rng_o;
   logic             wr_en;
   logic             start_req;
   logic             abort_req;
   logic             busy;
   logic [WIDTH-1:0] rd_mux;

   test_sequencer_rng #(
      .WIDTH     (WIDTH),
      .i_initial (SEED)
   ) u_rng (
      .clk    (clk),
      .reset  (reset),
      .enable (rng_enable),
      .o      (rng_o)
   );

   // A write coinciding with a read is dropped
   assign wr_en     = bus.slave_write && !bus.slave_read;
   assign start_req = wr_en && (bus.slave_address == CTRL_ADDR) && bus.slave_writedata[CTRL_START_BIT];
   assign abort_req = wr_en && (bus.slave_address == CTRL_ADDR) && bus.slave_writedata[CTRL_ABORT_BIT];
   assign busy      = (state_q == S_GEN_A) || (state_q == S_GEN_B) ||
                      (state_q == S_ISSUE) || (state_q == S_WAIT_RES);

   // Sequencer FSM next state, run counters, checksum and operand capture
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      done_cnt_d  = done_cnt_q;
      checksum_d  = checksum_q;
      dut_a_d     = dut_a_q;
      dut_b_d     = dut_b_q;
      done_d      = done_q;
      rng_enable  = 1'b0;
`ifdef TEST_SEQ_TIMEOUT_EN
      timeout_d   = timeout_q;
      wdog_d      = '0;
`endif

      // COUNT is only writable while the sequencer is idle
      if (wr_en && (bus.slave_address == COUNT_ADDR) && (state_q == S_IDLE)) begin
         count_d = bus.slave_writedata;
      end

      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               done_cnt_d = '0;
               checksum_d = '0;
               done_d     = 1'b0;
`ifdef TEST_SEQ_TIMEOUT_EN
               timeout_d  = 1'b0;
`endif
               if (count_q != '0) begin
                  remaining_d = count_q;
                  state_d     = S_GEN_A;
               end else begin
                  state_d     = S_DONE;
               end
            end
         end
         S_GEN_A: begin
            dut_a_d    = rng_o;
            rng_enable = 1'b1;
            state_d    = S_GEN_B;
         end
         S_GEN_B: begin
            dut_b_d    = rng_o;
            rng_enable = 1'b1;
            state_d    = S_ISSUE;
         end
         S_ISSUE: begin
            if (bus.dut_ready) begin
               state_d = S_WAIT_RES;
            end
         end
         S_WAIT_RES: begin
            if (bus.dut_o_valid) begin
               checksum_d  = {checksum_q[WIDTH-2:0], checksum_q[WIDTH-1]} ^ bus.dut_o;
               done_cnt_d  = done_cnt_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               state_d     = (remaining_q == WIDTH'(1)) ? S_DONE : S_GEN_A;
`ifdef TEST_SEQ_TIMEOUT_EN
            end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               wdog_d = wdog_q + 1'b1;
`endif
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort leaves partial counts in place and never reports completion
      if (abort_req && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         done_d  = done_q;
`ifdef TEST_SEQ_TIMEOUT_EN
         timeout_d = timeout_q;
`endif
      end
   end

   // Avalon read mux; readdata only updates on a read strobe
   always_comb begin
      rd_mux = '0;
      case (bus.slave_address)
         CTRL_ADDR: begin
            rd_mux[STAT_BUSY_BIT]    = busy;
            rd_mux[STAT_DONE_BIT]    = done_q;
            rd_mux[STAT_TIMEOUT_BIT] = timeout_flag;
         end
         COUNT_ADDR: rd_mux = count_q;
         DONE_ADDR:  rd_mux = done_cnt_q;
         CHK_ADDR:   rd_mux = checksum_q;
         default:    rd_mux = '0;
      endcase
      readdata_d = bus.slave_read ? rd_mux : readdata_q;
   end

   // State and register bank
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         remaining_q <= '0;
         done_cnt_q  <= '0;
         checksum_q  <= '0;
         dut_a_q     <= '0;
         dut_b_q     <= '0;
         readdata_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         done_cnt_q  <= done_cnt_d;
         checksum_q  <= checksum_d;
         dut_a_q     <= dut_a_d;
         dut_b_q     <= dut_b_d;
         readdata_q  <= readdata_d;
         done_q      <= done_d;
      end
   end

`ifdef TEST_SEQ_TIMEOUT_EN
   // Watchdog counter and timeout flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
      end
   end
`endif

   assign bus.slave_readdata = readdata_q;
   assign bus.dut_a          = dut_a_q;
   assign bus.dut_b          = dut_b_q;
   assign bus.dut_valid      = (state_q == S_ISSUE);

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: register table, directed multi-cycle
// scenarios, and randomized runs against a behavioural DUT/checksum model.
module tb_test_sequencer;
   import test_seq_pkg::*;

   localparam int WIDTH = 32;
`ifdef TEST_SEQ_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   test_sequencer_if #(.WIDTH(WIDTH)) bus ();

   test_sequencer #(
      .WIDTH          (WIDTH),
      .SEED           (32'hFFFF),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural DUT + scoreboard ----------------
   typedef struct {
      logic [31:0] res;
      int          due;
   } pend_t;

   pend_t       pend_q[$];
   int          cyc = 0;
   int          stall_min = 0, stall_max = 0, lat_min = 1, lat_max = 1, drop_from = 0;
   int          run_hs = 0, total_hs = 0, exp_done = 0, drop_errors = 0;
   logic [31:0] exp_chk = '0;
   logic [31:0] first_a = '0;
   logic        allow_drop = 1'b0;

   // Responds to operand handshakes with o = a + b after a random latency
   initial begin : responder
      logic [31:0] hold_a, hold_b;
      logic        in_issue, last_grant;
      int          stall_left;
      pend_t       p;
      in_issue = 1'b0; last_grant = 1'b0; stall_left = 0;
      hold_a = '0; hold_b = '0;
      bus.dut_ready = 1'b0; bus.dut_o = '0; bus.dut_o_valid = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.dut_o_valid = 1'b0;
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            bus.dut_o = p.res;
            bus.dut_o_valid = 1'b1;
            exp_chk = {exp_chk[30:0], exp_chk[31]} ^ p.res;
            exp_done++;
         end
         if (bus.dut_valid === 1'b1) begin
            if (!in_issue) begin
               in_issue   = 1'b1;
               last_grant = 1'b0;
               hold_a     = bus.dut_a;
               hold_b     = bus.dut_b;
               stall_left = $urandom_range(stall_max, stall_min);
            end else begin
               check("issue_a_stable", bus.dut_a, hold_a);
               check("issue_b_stable", bus.dut_b, hold_b);
            end
            if (stall_left > 0) begin
               bus.dut_ready = 1'b0;
               stall_left--;
            end else begin
               bus.dut_ready = 1'b1;
               last_grant    = 1'b1;
               run_hs++;
               total_hs++;
               if (total_hs == 1) first_a = hold_a;
               check("operands_differ", {31'b0, hold_a != hold_b}, 32'd1);
               if (drop_from == 0 || run_hs < drop_from)
                  pend_q.push_back('{res: hold_a + hold_b, due: cyc + $urandom_range(lat_max, lat_min)});
            end
         end else begin
            if (in_issue && !last_grant && !allow_drop) drop_errors++;
            in_issue      = 1'b0;
            bus.dut_ready = 1'b0;
         end
      end
   end

   // ---------------- host-side tasks (called at a negedge) ----------------
   task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
      bus.slave_address = addr; bus.slave_writedata = data; bus.slave_write = 1'b1;
      @(negedge clk);
      bus.slave_write = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
      bus.slave_address = addr; bus.slave_read = 1'b1;
      @(negedge clk);
      bus.slave_read = 1'b0;
      data = bus.slave_readdata;
   endtask

   task automatic bus_rw(input logic [3:0] addr, input logic [31:0] wdata, output logic [31:0] data);
      bus.slave_address = addr; bus.slave_writedata = wdata;
      bus.slave_read = 1'b1; bus.slave_write = 1'b1;
      @(negedge clk);
      bus.slave_read = 1'b0; bus.slave_write = 1'b0;
      data = bus.slave_readdata;
   endtask

   task automatic set_dut(input int smin, input int smax, input int lmin, input int lmax, input int drop);
      stall_min = smin; stall_max = smax; lat_min = lmin; lat_max = lmax; drop_from = drop;
   endtask

   task automatic start_run(input int count);
      exp_chk = '0; exp_done = 0; run_hs = 0;
      bus_write(COUNT_ADDR, count);
      bus_write(CTRL_ADDR, 32'h1);
   endtask

   task automatic wait_hs(input string name, input int target, input int max_cycles);
      int n = 0;
      while (run_hs < target && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check({name, "_handshake_seen"}, {31'b0, run_hs >= target}, 32'd1);
   endtask

   task automatic wait_done(input string name, input int max_polls, output logic [31:0] status, output int polls);
      status = '0; polls = 0;
      while (polls < max_polls) begin
         bus_read(CTRL_ADDR, status);
         polls++;
         if (status[STAT_DONE_BIT]) break;
      end
      check({name, "_done_reached"}, {31'b0, status[STAT_DONE_BIT]}, 32'd1);
   endtask

   task automatic check_results(input string name, input int count, input logic [31:0] exp_status);
      logic [31:0] st, dc, ck;
      int          polls;
      wait_done(name, 200 * count + 50, st, polls);
      check({name, "_status"}, st, exp_status);
      bus_read(DONE_ADDR, dc);
      check({name, "_done_cnt"}, dc, count);
      bus_read(CHK_ADDR, ck);
      check({name, "_checksum"}, ck, exp_chk);
   endtask

   // ---------------- register table ----------------
   typedef struct {
      logic [3:0]  addr;
      logic        wr;
      logic        rd_same;
      logic [31:0] wdata;
      logic [31:0] exp;
   } reg_vec_t;

   initial begin : watchdog
      #500_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : main
      reg_vec_t    vecs[11];
      logic [31:0] r, dummy, st;
      int          polls, valid_before, hs_before;

      vecs[0]  = '{CTRL_ADDR,  1'b0, 1'b0, 32'h0,         32'h0};
      vecs[1]  = '{COUNT_ADDR, 1'b0, 1'b0, 32'h0,         32'h0};
      vecs[2]  = '{DONE_ADDR,  1'b0, 1'b0, 32'h0,         32'h0};
      vecs[3]  = '{CHK_ADDR,   1'b0, 1'b0, 32'h0,         32'h0};
      vecs[4]  = '{COUNT_ADDR, 1'b1, 1'b0, 32'h7,         32'h7};
      vecs[5]  = '{4'h2,       1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
      vecs[6]  = '{DONE_ADDR,  1'b1, 1'b0, 32'h55,        32'h0};
      vecs[7]  = '{CHK_ADDR,   1'b1, 1'b0, 32'h55,        32'h0};
      vecs[8]  = '{COUNT_ADDR, 1'b1, 1'b1, 32'h9,         32'h7};
      vecs[9]  = '{4'hF,       1'b0, 1'b0, 32'h0,         32'h0};
      vecs[10] = '{COUNT_ADDR, 1'b1, 1'b0, 32'h0,         32'h0};

      reset = 1'b0;
      bus.slave_address = '0; bus.slave_read = 1'b0; bus.slave_write = 1'b0; bus.slave_writedata = '0;
      repeat (3) @(negedge clk);
      check("reset_readdata", bus.slave_readdata, 32'h0);
      check("reset_dut_valid", {31'b0, bus.dut_valid}, 32'h0);
      check("reset_dut_a", bus.dut_a, 32'h0);
      check("reset_dut_b", bus.dut_b, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].wr && vecs[i].rd_same) bus_rw(vecs[i].addr, vecs[i].wdata, dummy);
         else if (vecs[i].wr)               bus_write(vecs[i].addr, vecs[i].wdata);
         bus_read(vecs[i].addr, r);
         check($sformatf("reg_vec_%0d", i), r, vecs[i].exp);
      end

      // readdata holds between reads
      bus_write(COUNT_ADDR, 32'd5);
      bus_read(COUNT_ADDR, r);
      bus_write(COUNT_ADDR, 32'd3);
      repeat (2) @(negedge clk);
      check("readdata_holds", bus.slave_readdata, 32'd5);
      bus_read(COUNT_ADDR, r);
      check("count_rewritten", r, 32'd3);

      // 1: three vectors, always ready, 2-cycle latency
      set_dut(0, 0, 2, 2, 0);
      start_run(3);
      check_results("t1", 3, 32'b010);
      check("t1_handshakes", run_hs, 32'd3);
      check("t1_first_operand_is_seed", first_a, 32'h0000_FFFF);

      // 2: COUNT=0 finishes without a DUT transaction and clears the result registers
      valid_before = total_hs;
      exp_chk = '0;
      bus_write(COUNT_ADDR, 32'd0);
      bus_write(CTRL_ADDR, 32'h1);
      wait_done("t2", 3, st, polls);
      check("t2_status", st, 32'b010);
      check("t2_no_handshake", total_hs, valid_before);
      bus_read(DONE_ADDR, r);
      check("t2_done_cnt", r, 32'd0);
      bus_read(CHK_ADDR, r);
      check("t2_checksum", r, 32'd0);

      // 3: ready held low for 5 ISSUE cycles
      set_dut(5, 5, 1, 3, 0);
      start_run(2);
      check_results("t3", 2, 32'b010);

      // 4: abort in the second WAIT_RES, then a clean rerun
      set_dut(0, 1, 1, 3, 2);
      start_run(5);
      wait_hs("t4", 2, 200);
      @(negedge clk);
      bus_write(CTRL_ADDR, 32'h2);
      bus_read(CTRL_ADDR, r);
      check("t4_status_after_abort", r, 32'h0);
      bus_read(DONE_ADDR, r);
      check("t4_done_cnt_partial", r, 32'd1);
      bus_read(CHK_ADDR, r);
      check("t4_checksum_partial", r, exp_chk);
      hs_before = total_hs;
      repeat (10) @(negedge clk);
      check("t4_quiet_after_abort", total_hs, hs_before);
      set_dut(0, 2, 1, 3, 0);
      start_run(3);
      check_results("t4_rerun", 3, 32'b010);

      // 5: START and COUNT writes while busy are ignored
      set_dut(1, 1, 3, 3, 0);
      start_run(4);
      wait_hs("t5", 1, 200);
      bus_write(CTRL_ADDR, 32'h1);
      bus_write(COUNT_ADDR, 32'd9);
      check_results("t5", 4, 32'b010);
      bus_read(COUNT_ADDR, r);
      check("t5_count_kept", r, 32'd4);
      check("t5_handshakes", run_hs, 32'd4);

      // 6: DUT never answers
      set_dut(0, 0, 1, 1, 1);
      start_run(2);
      wait_hs("t6", 1, 200);
`ifdef TEST_SEQ_TIMEOUT_EN
      wait_done("t6", 60, st, polls);
      check("t6_status", st, 32'b110);
      check("t6_timeout_delay", {31'b0, (polls >= 14) && (polls <= 22)}, 32'd1);
      bus_read(DONE_ADDR, r);
      check("t6_done_cnt", r, 32'd0);
`else
      repeat (40) @(negedge clk);
      bus_read(CTRL_ADDR, r);
      check("t6_still_waiting", r, 32'b001);
      bus_write(CTRL_ADDR, 32'h2);
      bus_read(CTRL_ADDR, r);
      check("t6_abort_status", r, 32'h0);
`endif

      // randomized runs against the model
      for (int k = 0; k < 6; k++) begin
         int cnt;
         int smax;
         int lmax;
         cnt  = $urandom_range(6, 1);
         smax = $urandom_range(3, 0);
         lmax = $urandom_range(4, 1);
         set_dut(0, smax, 1, lmax, 0);
         start_run(cnt);
         check_results($sformatf("rand_%0d", k), cnt, 32'b010);
      end

      // asynchronous reset mid-run
      set_dut(0, 0, 2, 2, 0);
      allow_drop = 1'b1;
      start_run(3);
      wait_hs("rst", 1, 200);
      #2 reset = 1'b0;
      #1;
      check("rst_dut_valid", {31'b0, bus.dut_valid}, 32'h0);
      check("rst_dut_a", bus.dut_a, 32'h0);
      pend_q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus_read(DONE_ADDR, r);
      check("rst_done_cnt", r, 32'd0);
      bus_read(COUNT_ADDR, r);
      check("rst_count", r, 32'd0);
      bus_read(CTRL_ADDR, r);
      check("rst_status", r, 32'd0);

      check("valid_drops_without_ready", drop_errors, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
